traffic_countdown: RTL and testbench

TRAFFIC_COUNTDOWN -- requirements
Module: traffic_countdown

---
 rtl/traffic_pkg.sv | 42 ++++
 rtl/traffic_countdown_if.sv | 32 +++
 rtl/tick_prescaler.sv | 55 +++++
 rtl/traffic_countdown.sv | 171 +++++++++++++++++
 tb/tb_traffic_countdown.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the traffic-light countdown block:
//   state_t      - countdown FSM states (IDLE / RUN / HOLD)
//   bcd_digit_t  - one 4-bit BCD digit
//   BLANK_CODE   - digit code the seven-segment decoder renders as "off"
//   bin_to_bcd   - 7-bit binary (0..99) to two BCD digits {tens, ones}
//   bcd_dec      - decrement a non-zero two-digit BCD value by one
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_CODE = 4'hF;

    // Caller guarantees bin <= 99, so both quotient and remainder fit a digit.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        bcd_digit_t t;
        bcd_digit_t o;
        t = 4'(bin / 7'd10);
        o = 4'(bin % 7'd10);
        return {t, o};
    endfunction

    // Borrow from the tens digit when the ones digit is already zero.
    function automatic logic [7:0] bcd_dec(input bcd_digit_t t, input bcd_digit_t o);
        logic [7:0] r;
        if (o == 4'd0) begin
            r = {t - 4'd1, 4'd9};
        end else begin
            r = {t, o - 4'd1};
        end
        return r;
    endfunction

endpackage : traffic_pkg

// File: rtl/traffic_countdown_if.sv
// ---------------------------------------------------------------------------
// traffic_countdown_if
// Control and display bundle of the countdown block.
//   load      - single-cycle request to start a countdown from load_val
//   load_val  - phase duration in seconds (unsigned binary)
//   pause     - level; freezes count and prescaler while high
//   tens/ones - BCD digits towards the seven-segment decoder
//   busy      - countdown active (RUN or HOLD)
//   done      - one-cycle pulse at expiry (or on a load of zero)
// Modports: master = controller side, slave = countdown block.
// ---------------------------------------------------------------------------
interface traffic_countdown_if;

    logic       load;
    logic [6:0] load_val;
    logic       pause;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;

    modport master (
        output load, load_val, pause,
        input  tens, ones, busy, done
    );

    modport slave (
        input  load, load_val, pause,
        output tens, ones, busy, done
    );

endinterface : traffic_countdown_if

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - restart the division from zero (wins over en)
//   en    - advance the divider this cycle; when low the count holds
//   tick  - high in the enabled cycle in which the divider wraps
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick is qualified by en so a frozen divider never emits a tick.
    assign tick = en && (cnt_q == LAST);

    // Next divider value: clear, wrap or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/traffic_countdown.sv
// ---------------------------------------------------------------------------
// traffic_countdown
// Seconds countdown for a traffic-light phase, shown as two BCD digits.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - traffic_countdown_if.slave (load/load_val/pause in,
//           tens/ones/busy/done out; all outputs registered)
// Parameters:
//   TICK_DIV - clock cycles per one-second tick (>= 2)
//   MAX_SEC  - largest loadable count; larger load_val saturates (<= 99)
// Build option:
//   COUNTDOWN_BLANK_EN - when defined, tens is driven as BLANK_CODE while the
//   internal tens digit is zero so the decoder suppresses the leading zero.
//   Only the displayed tens value changes; count, state, busy and done do not.
// ---------------------------------------------------------------------------
module traffic_countdown #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_SEC  = 99
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_countdown_if.slave   bus
);

    import traffic_pkg::*;

    localparam logic [6:0] MAX_SEC_C = 7'(MAX_SEC);

`ifdef COUNTDOWN_BLANK_EN
    localparam bcd_digit_t TENS_DISP_RST = BLANK_CODE;
`else
    localparam bcd_digit_t TENS_DISP_RST = 4'd0;
`endif

    state_t     state_q, state_d;
    bcd_digit_t tens_q, tens_d;
    bcd_digit_t ones_q, ones_d;
    bcd_digit_t tens_disp_q, tens_disp_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [6:0] sat_s;
    logic [7:0] load_bcd_s;
    logic [7:0] dec_bcd_s;
    logic       pre_en_s;
    logic       tick_s;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.load),
        .en    (pre_en_s),
        .tick  (tick_s)
    );

    // Saturate the requested duration and pre-compute load/decrement values.
    always_comb begin
        if (bus.load_val > MAX_SEC_C) begin
            sat_s = MAX_SEC_C;
        end else begin
            sat_s = bus.load_val;
        end
        load_bcd_s = bin_to_bcd(sat_s);
        dec_bcd_s  = bcd_dec(tens_q, ones_q);
    end

    // The divider runs in an active countdown unless paused or being reloaded.
    // HOLD with pause released advances too, so resuming costs no cycle.
    always_comb begin
        if (!bus.load && (state_q != ST_IDLE) && !bus.pause) begin
            pre_en_s = 1'b1;
        end else begin
            pre_en_s = 1'b0;
        end
    end

    // FSM next state, digit update and done generation; load has top priority.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        if (bus.load) begin
            tens_d = load_bcd_s[7:4];
            ones_d = load_bcd_s[3:0];
            if (sat_s == 7'd0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                done_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN, ST_HOLD: begin
                    if (bus.pause) begin
                        state_d = ST_HOLD;
                    end else if (tick_s) begin
                        // 01 -> 00 is expiry; a stray 00 is also retired safely.
                        if ((tens_q == 4'd0) && (ones_q <= 4'd1)) begin
                            tens_d  = 4'd0;
                            ones_d  = 4'd0;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            tens_d  = dec_bcd_s[7:4];
                            ones_d  = dec_bcd_s[3:0];
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end
            endcase
        end
    end

    // Registered status and display mapping of the tens digit.
    always_comb begin
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
`ifdef COUNTDOWN_BLANK_EN
        if (tens_d == 4'd0) begin
            tens_disp_d = BLANK_CODE;
        end else begin
            tens_disp_d = tens_d;
        end
`else
        tens_disp_d = tens_d;
`endif
    end

    // State, digit and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            tens_disp_q <= TENS_DISP_RST;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            tens_disp_q <= tens_disp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.tens = tens_disp_q;
    assign bus.ones = ones_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule : traffic_countdown

// File: tb/tb_traffic_countdown.sv
// ---------------------------------------------------------------------------
// tb_traffic_countdown
// Self-checking bench for traffic_countdown with TICK_DIV=4.
// Table of load vectors plus hand-written pause / reset / reload sequences;
// expectations go through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_traffic_countdown;

    logic clk;
    logic rst_n;

    traffic_countdown_if bus ();

    traffic_countdown #(
        .TICK_DIV (4),
        .MAX_SEC  (99)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] lv;
        int         wait_n;
        logic [3:0] t;
        logic [3:0] o;
        logic       b;
        logic       d;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] t;
        logic [3:0] o;
        logic       b;
        logic       d;
    } exp_t;

    vec_t vecs [16];
    exp_t sb_q [$];
    int   n_vec;
    int   n_err;

    // Displayed tens for a given internal tens digit.
    function automatic logic [3:0] disp_tens(input logic [3:0] t);
`ifdef COUNTDOWN_BLANK_EN
        if (t == 4'd0) return 4'hF;
        return t;
`else
        return t;
`endif
    endfunction

    task automatic push_exp(input string n, input logic [3:0] t, input logic [3:0] o,
                            input logic b, input logic d);
        exp_t e;
        e.name = n;
        e.t    = disp_tens(t);
        e.o    = o;
        e.b    = b;
        e.d    = d;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expectation queued");
        end else begin
            e = sb_q.pop_front();
            if (bus.tens !== e.t || bus.ones !== e.o || bus.busy !== e.b || bus.done !== e.d) begin
                n_err++;
                $display("FAIL %s: got tens=%h ones=%h busy=%b done=%b, expected tens=%h ones=%h busy=%b done=%b",
                         e.name, bus.tens, bus.ones, bus.busy, bus.done, e.t, e.o, e.b, e.d);
            end
        end
    endtask

    // Returns at the falling edge right after the rising edge that sampled load.
    task automatic load_value(input logic [6:0] v);
        @(negedge clk);
        bus.load     = 1'b1;
        bus.load_val = v;
        @(negedge clk);
        bus.load     = 1'b0;
        bus.load_val = 7'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        //                 load  wait  tens  ones  busy  done
        vecs[0]  = '{7'd12,   0, 4'd1, 4'd2, 1'b1, 1'b0};
        vecs[1]  = '{7'd12,   3, 4'd1, 4'd2, 1'b1, 1'b0};
        vecs[2]  = '{7'd12,   4, 4'd1, 4'd1, 1'b1, 1'b0};
        vecs[3]  = '{7'd12,  47, 4'd0, 4'd1, 1'b1, 1'b0};
        vecs[4]  = '{7'd12,  48, 4'd0, 4'd0, 1'b0, 1'b1};
        vecs[5]  = '{7'd12,  49, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{7'd10,   3, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[7]  = '{7'd10,   4, 4'd0, 4'd9, 1'b1, 1'b0};
        vecs[8]  = '{7'd127,  0, 4'd9, 4'd9, 1'b1, 1'b0};
        vecs[9]  = '{7'd100,  0, 4'd9, 4'd9, 1'b1, 1'b0};
        vecs[10] = '{7'd99,   4, 4'd9, 4'd8, 1'b1, 1'b0};
        vecs[11] = '{7'd0,    0, 4'd0, 4'd0, 1'b0, 1'b1};
        vecs[12] = '{7'd0,    1, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[13] = '{7'd7,    0, 4'd0, 4'd7, 1'b1, 1'b0};
        vecs[14] = '{7'd20,   8, 4'd1, 4'd8, 1'b1, 1'b0};
        vecs[15] = '{7'd1,    4, 4'd0, 4'd0, 1'b0, 1'b1};

        bus.load     = 1'b0;
        bus.load_val = 7'd0;
        bus.pause    = 1'b0;
        rst_n        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        push_exp("reset_state", 4'd0, 4'd0, 1'b0, 1'b0);
        check_pop();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_exp("idle_after_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        check_pop();

        // Table-driven load vectors
        for (int i = 0; i < 16; i++) begin
            load_value(vecs[i].lv);
            push_exp($sformatf("vec%0d_load%0d_wait%0d", i, vecs[i].lv, vecs[i].wait_n),
                     vecs[i].t, vecs[i].o, vecs[i].b, vecs[i].d);
            repeat (vecs[i].wait_n) @(negedge clk);
            check_pop();
        end

        // Pause ignored in IDLE
        load_value(7'd0);
        bus.pause = 1'b1;
        repeat (6) @(negedge clk);
        push_exp("pause_in_idle", 4'd0, 4'd0, 1'b0, 1'b0);
        check_pop();
        bus.pause = 1'b0;

        // Pause after two prescaler counts, hold 20 cycles, resume
        load_value(7'd5);
        repeat (2) @(negedge clk);
        bus.pause = 1'b1;
        repeat (20) @(negedge clk);
        push_exp("pause_hold_20", 4'd0, 4'd5, 1'b1, 1'b0);
        check_pop();
        bus.pause = 1'b0;
        @(negedge clk);
        push_exp("pause_release_1", 4'd0, 4'd5, 1'b1, 1'b0);
        check_pop();
        @(negedge clk);
        push_exp("pause_release_2", 4'd0, 4'd4, 1'b1, 1'b0);
        check_pop();

        // Asynchronous reset mid-countdown at 07
        load_value(7'd10);
        repeat (12) @(negedge clk);
        push_exp("before_reset_07", 4'd0, 4'd7, 1'b1, 1'b0);
        check_pop();
        rst_n = 1'b0;
        #1;
        push_exp("async_reset_immediate", 4'd0, 4'd0, 1'b0, 1'b0);
        check_pop();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                push_exp("no_done_after_reset", 4'd0, 4'd0, 1'b0, 1'b0);
                check_pop();
            end
        end
        push_exp("idle_after_mid_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        check_pop();

        // Reload during RUN at 30 with 08: prescaler restarts
        load_value(7'd30);
        repeat (2) @(negedge clk);
        load_value(7'd8);
        push_exp("reload_08", 4'd0, 4'd8, 1'b1, 1'b0);
        check_pop();
        repeat (3) @(negedge clk);
        push_exp("reload_prescaler_3", 4'd0, 4'd8, 1'b1, 1'b0);
        check_pop();
        @(negedge clk);
        push_exp("reload_prescaler_4", 4'd0, 4'd7, 1'b1, 1'b0);
        check_pop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_traffic_countdown
